// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV32I-subset processor.
// Each clk retires one instruction. Fetch, decode, execute and writeback all
// happen in one combinational pass between edges. Three sub-blocks are used:
// the register file (RF), the instruction memory (IMEM, loaded from outside
// by hierarchical write) and the data memory (DMEM). EBREAK freezes the core
// and raises halt until reset.

// 32x32 register file: two combinational read ports, one write port.
// Reset clears every register; x0 ignores writes and always reads zero.
module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    logic [31:0] regs [0:31];

    // Clear all registers on reset; otherwise write rd on the rising edge unless it is x0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];
endmodule

// Word-addressed instruction ROM with no write port. Its contents are
// preloaded from outside. An address beyond the array returns all zeros,
// which the core executes as a no-op.
module cpu_imem #(
    parameter int WORDS = 256
) (
    input  logic [29:0] word_addr,
    output logic [31:0] instr
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [0:WORDS-1];
    logic        in_range;

    assign in_range = ({2'b00, word_addr} < 32'(WORDS));
    assign instr    = in_range ? mem[word_addr[AW-1:0]] : 32'h0;
endmodule

// Word-addressed data RAM with a combinational read and a synchronous write.
// Out-of-range reads return zero, and out-of-range writes are dropped.
module cpu_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] word_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] mem [0:WORDS-1];
    logic        in_range;

    assign in_range = ({2'b00, word_addr} < 32'(WORDS));
    assign rdata    = in_range ? mem[word_addr[AW-1:0]] : 32'h0;

    // Store a word on the rising edge when the address is inside the array
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[word_addr[AW-1:0]] <= wdata;
        end
    end
endmodule

module cpu_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic clk,
    input  logic reset,
    output logic halt
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] EBREAK_WORD = 32'h00100073;

    logic [31:0] pc_val;
    logic [31:0] pc_plus4;
    logic [31:0] instr;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] dm_addr;
    logic [31:0] dm_rdata;

    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        dm_we;
    logic        is_ebreak;
    logic        take;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        unused_bits;

    // Shared ALU for register-register and register-immediate operations.
    // alt selects SUB over ADD, and arithmetic over logical right shift.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, ($signed(a) < $signed(b))};
            3'b011:  r = {31'b0, (a < b)};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign pc_plus4 = pc_val + 32'd4;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Loads and stores share one address adder input, with the immediate chosen by format
    assign dm_addr = rs1_data + ((opcode == OP_STORE) ? imm_s : imm_i);

    // Low address bits are dropped on purpose: memories are word addressed
    // and PC targets are word-truncated.
    assign unused_bits = ^{dm_addr[1:0], target[1:0], pc_val[1:0]};

    cpu_imem #(.WORDS(IMEM_WORDS)) IMEM (
        .word_addr (pc_val[31:2]),
        .instr     (instr)
    );

    cpu_regfile RF (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (rf_we && !halt),
        .rd_addr  (rd),
        .rd_data  (rf_wdata)
    );

    cpu_dmem #(.WORDS(DMEM_WORDS)) DMEM (
        .clk       (clk),
        .we        (dm_we && !halt),
        .word_addr (dm_addr[31:2]),
        .wdata     (rs2_data),
        .rdata     (dm_rdata)
    );

    // Decode and execute the current instruction. Unlisted or illegal encodings fall through as no-ops.
    always_comb begin
        rf_we     = 1'b0;
        rf_wdata  = 32'h0;
        dm_we     = 1'b0;
        is_ebreak = 1'b0;
        take      = 1'b0;
        target    = pc_plus4;
        case (opcode)
            OP_LUI: begin
                rf_we    = 1'b1;
                rf_wdata = imm_u;
            end
            OP_AUIPC: begin
                rf_we    = 1'b1;
                rf_wdata = pc_val + imm_u;
            end
            OP_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                target   = pc_val + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_plus4;
                    target   = (rs1_data + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  take = (rs1_data == rs2_data);
                    3'b001:  take = (rs1_data != rs2_data);
                    3'b100:  take = ($signed(rs1_data) <  $signed(rs2_data));
                    3'b101:  take = ($signed(rs1_data) >= $signed(rs2_data));
                    3'b110:  take = (rs1_data <  rs2_data);
                    3'b111:  take = (rs1_data >= rs2_data);
                    default: take = 1'b0;
                endcase
                if (take) begin
                    target = pc_val + imm_b;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    rf_we    = 1'b1;
                    rf_wdata = dm_rdata;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    dm_we = 1'b1;
                end
            end
            OP_IMM: begin
                if ((funct3 == 3'b001 && funct7 == 7'b0000000) ||
                    (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_data, imm_i);
                end
            end
            OP_REG: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu(funct3, instr[30], rs1_data, rs2_data);
                end
            end
            OP_SYSTEM: begin
                is_ebreak = (instr == EBREAK_WORD);
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
        next_pc = {target[31:2], 2'b00};
    end

    // Advance the PC each edge until EBREAK retires, then hold the PC and raise the sticky halt flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_val <= RESET_PC;
            halt   <= 1'b0;
        end else if (!halt) begin
            if (is_ebreak) begin
                halt <= 1'b1;
            end else begin
                pc_val <= next_pc;
            end
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed program tests for cpu_core.
// Expected PC traces and final register values go into queues when each
// program is loaded. They are then popped and compared as the core runs.
module tb_cpu_core;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [31:0] EBREAK_WORD = 32'h00100073;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } reg_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic halt;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] prog[$];
    logic [31:0] pcQueue[$];
    reg_exp_t    regQueue[$];

    always #5 clk = ~clk;

    cpu_core #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .RESET_PC   (32'h0)
    ) DUT (
        .clk   (clk),
        .reset (reset),
        .halt  (halt)
    );

    function automatic logic [31:0] encI(input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [31:0] f3, input logic [31:0] rd,
                                         input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] encR(input logic [31:0] f7, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3,
                                         input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_REG};
    endfunction

    function automatic logic [31:0] encS(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encU(input logic [31:0] imm20, input logic [31:0] rd);
        return {imm20[19:0], rd[4:0], OP_LUI};
    endfunction

    function automatic logic [31:0] encJ(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Hold reset, clear both memories, load the program and wait for a falling edge
    task automatic applyStimulus();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            DUT.IMEM.mem[i] = 32'h0;
            DUT.DMEM.mem[i] = 32'h0;
        end
        for (int i = 0; i < prog.size(); i++) begin
            DUT.IMEM.mem[i] = prog[i];
        end
        @(negedge clk);
    endtask

    task automatic expectPc(input logic [31:0] pcs[$]);
        foreach (pcs[i]) pcQueue.push_back(pcs[i]);
    endtask

    task automatic expectReg(input int idx, input logic [31:0] val);
        reg_exp_t e;
        e.idx = idx;
        e.val = val;
        regQueue.push_back(e);
    endtask

    // Compare one traced PC per cycle. The loop is bounded by the trace length.
    task automatic runTrace(input string tag);
        logic [31:0] expPc;
        while (pcQueue.size() > 0) begin
            expPc = pcQueue.pop_front();
            checkOutput(tag, DUT.pc_val, expPc);
            @(negedge clk);
        end
    endtask

    task automatic drainRegs();
        reg_exp_t e;
        while (regQueue.size() > 0) begin
            e = regQueue.pop_front();
            checkOutput($sformatf("reg_x%0d", e.idx), DUT.RF.regs[e.idx], e.val);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;

        // Program 1: call and return through jalr
        prog = '{encI(16, 0, 0, 5, OP_IMM),
                 encI(0, 5, 0, 1, OP_JALR),
                 encI(99, 0, 0, 7, OP_IMM),
                 EBREAK_WORD,
                 encI(42, 0, 0, 6, OP_IMM),
                 encI(0, 1, 0, 0, OP_JALR)};
        applyStimulus();
        checkOutput("reset_pc", DUT.pc_val, 32'h0);
        checkOutput("reset_halt", {31'b0, halt}, 32'h0);
        reset = 1'b0;
        expectPc('{32'd0, 32'd4, 32'd16, 32'd20, 32'd8, 32'd12});
        expectReg(1, 32'd8);
        expectReg(5, 32'd16);
        expectReg(6, 32'd42);
        expectReg(7, 32'd99);
        runTrace("call_pc");
        checkOutput("call_halt", {31'b0, halt}, 32'h1);
        checkOutput("call_halt_pc", DUT.pc_val, 32'd12);
        drainRegs();

        // Core stays frozen after halt
        repeat (10) @(negedge clk);
        checkOutput("frozen_pc", DUT.pc_val, 32'd12);
        checkOutput("frozen_halt", {31'b0, halt}, 32'h1);
        checkOutput("frozen_x6", DUT.RF.regs[6], 32'd42);
        checkOutput("frozen_x1", DUT.RF.regs[1], 32'd8);

        // Asynchronous reset pulse, then run again
        reset = 1'b1;
        #1;
        checkOutput("rst_halt", {31'b0, halt}, 32'h0);
        checkOutput("rst_pc", DUT.pc_val, 32'h0);
        checkOutput("rst_x7", DUT.RF.regs[7], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        expectPc('{32'd0, 32'd4, 32'd16, 32'd20, 32'd8, 32'd12});
        expectReg(7, 32'd99);
        expectReg(1, 32'd8);
        runTrace("rerun_pc");
        checkOutput("rerun_halt", {31'b0, halt}, 32'h1);
        drainRegs();

        // Program 2: x0 writes, branches, memory access, arithmetic edges, jal
        prog = '{encI(5, 0, 0, 0, OP_IMM),
                 encR(0, 0, 0, 0, 9),
                 encI(5, 0, 0, 1, OP_IMM),
                 encI(5, 0, 0, 2, OP_IMM),
                 encB(8, 2, 1, 0),
                 encI(1, 0, 0, 10, OP_IMM),
                 encB(8, 2, 1, 1),
                 encI(-1, 0, 0, 11, OP_IMM),
                 encI(1, 0, 0, 12, OP_IMM),
                 encB(8, 12, 11, 4),
                 encI(2, 0, 0, 10, OP_IMM),
                 encB(8, 12, 11, 6),
                 encI(100, 0, 0, 3, OP_IMM),
                 encS(8, 3, 0),
                 encI(8, 0, 2, 4, OP_LOAD),
                 encI(1024, 0, 2, 3, OP_LOAD),
                 encU(32'h80000, 13),
                 encI(-1, 13, 0, 13, OP_IMM),
                 encU(32'h80000, 14),
                 encI(32'h41F, 14, 5, 15, OP_IMM),
                 encJ(8, 17),
                 encI(3, 0, 0, 10, OP_IMM),
                 EBREAK_WORD};
        applyStimulus();
        reset = 1'b0;
        expectPc('{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd24, 32'd28, 32'd32,
                   32'd36, 32'd44, 32'd48, 32'd52, 32'd56, 32'd60, 32'd64, 32'd68,
                   32'd72, 32'd76, 32'd80, 32'd88});
        expectReg(0, 32'h0);
        expectReg(9, 32'h0);
        expectReg(1, 32'd5);
        expectReg(2, 32'd5);
        expectReg(10, 32'h0);
        expectReg(11, 32'hFFFF_FFFF);
        expectReg(12, 32'd1);
        expectReg(4, 32'd100);
        expectReg(3, 32'h0);
        expectReg(13, 32'h7FFF_FFFF);
        expectReg(14, 32'h8000_0000);
        expectReg(15, 32'hFFFF_FFFF);
        expectReg(17, 32'd84);
        runTrace("mix_pc");
        checkOutput("mix_halt", {31'b0, halt}, 32'h1);
        checkOutput("mix_dmem2", DUT.DMEM.mem[2], 32'd100);
        drainRegs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
